// File: rtl/wasm_pkg.sv
// Shared WebAssembly memory-unit types: memory op encodings, trap codes,
// LSU state encoding and small op-classification helpers.
package wasm_pkg;

    typedef enum logic [3:0] {
        LOAD_I32           = 4'd0,
        LOAD_I64           = 4'd1,
        LOAD_I8_S          = 4'd2,
        LOAD_I8_U          = 4'd3,
        LOAD_I16_S         = 4'd4,
        LOAD_I16_U         = 4'd5,
        LOAD_I32_S         = 4'd6,
        LOAD_I32_U         = 4'd7,
        STORE_I8           = 4'd8,
        STORE_I16          = 4'd9,
        STORE_I32          = 4'd10,
        STORE_I32_FROM_I64 = 4'd11,
        STORE_I64          = 4'd12,
        MEM_SIZE           = 4'd13,
        MEM_GROW           = 4'd14
    } mem_op_t;

    typedef enum logic [1:0] {
        TRAP_NONE          = 2'd0,
        TRAP_OUT_OF_BOUNDS = 2'd1,
        TRAP_UNALIGNED     = 2'd2
    } trap_t;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD      = 3'd1,
        WR      = 3'd2,
        WR_WAIT = 3'd3,
        RESP    = 3'd4
    } lsu_state_t;

    function automatic logic is_load_op(input mem_op_t op);
        return op inside {LOAD_I32, LOAD_I64, LOAD_I8_S, LOAD_I8_U,
                          LOAD_I16_S, LOAD_I16_U, LOAD_I32_S, LOAD_I32_U};
    endfunction

    function automatic logic is_store_op(input mem_op_t op);
        return op inside {STORE_I8, STORE_I16, STORE_I32, STORE_I32_FROM_I64, STORE_I64};
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/wasm_lsu.sv
// Load/store unit: one memory instruction at a time, bounds check on the
// 33-bit effective address, single-cycle memory port access, held response.
module wasm_lsu
    import wasm_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  mem_op_t     req_op,
    input  logic [31:0] req_base,
    input  logic [31:0] req_offset,
    input  logic [63:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [63:0] rsp_data,
    output trap_t       rsp_trap,
    output logic        mem_rd_en,
    output logic [31:0] mem_rd_addr,
    output mem_op_t     mem_rd_op,
    input  logic [63:0] mem_rd_data,
    input  logic        mem_rd_valid,
    output logic        mem_wr_en,
    output logic [31:0] mem_wr_addr,
    output mem_op_t     mem_wr_op,
    output logic [63:0] mem_wr_data,
    input  logic        mem_wr_valid,
    input  trap_t       mem_trap,
    output logic [31:0] cnt_load,
    output logic [31:0] cnt_store,
    output logic [31:0] cnt_trap,
    output lsu_state_t  fsm_state
);

    // Handshakes: a transfer happens on a clock edge where valid and ready are
    // both high; valid holds its payload stable until that edge.
    lsu_state_t  state, state_d;
    mem_op_t     op_q;
    logic [31:0] addr_q;
    logic [63:0] wdata_q;
    logic [63:0] data_q;
    trap_t       trap_q;
    logic [32:0] ea;
    logic        accept;
    logic        rsp_done;

    assign ea        = {1'b0, req_base} + {1'b0, req_offset};
    assign accept    = req_valid && req_ready;
    assign rsp_done  = rsp_valid && rsp_ready;
    assign fsm_state = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_d;
    end

    always_comb begin
        state_d   = state;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        mem_rd_en = 1'b0;
        mem_wr_en = 1'b0;
        unique case (state)
            IDLE: begin
                // Held low while reset is asserted even though state reads IDLE.
                req_ready = rst_n;
                if (req_valid && rst_n) begin
                    if (ea[32])                state_d = RESP;
                    else if (is_load_op(req_op))  state_d = RD;
                    else if (is_store_op(req_op)) state_d = WR;
                    else                       state_d = RESP;
                end
            end
            RD: begin
                mem_rd_en = 1'b1;
                state_d   = RESP;
            end
            WR: begin
                mem_wr_en = 1'b1;
                state_d   = (mem_trap != TRAP_NONE) ? RESP : WR_WAIT;
            end
            WR_WAIT: if (mem_wr_valid) state_d = RESP;
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q      <= LOAD_I32;
            addr_q    <= '0;
            wdata_q   <= '0;
            data_q    <= '0;
            trap_q    <= TRAP_NONE;
            cnt_load  <= '0;
            cnt_store <= '0;
            cnt_trap  <= '0;
        end else begin
            if (accept) begin
                op_q    <= req_op;
                addr_q  <= ea[31:0];
                wdata_q <= req_wdata;
                data_q  <= '0;
                trap_q  <= ea[32] ? TRAP_OUT_OF_BOUNDS : TRAP_NONE;
            end
            if (state == RD) begin
                data_q <= mem_rd_valid ? mem_rd_data : 64'd0;
                trap_q <= mem_rd_valid ? TRAP_NONE : mem_trap;
            end
            if (state == WR) trap_q <= mem_trap;
            if (rsp_done) begin
                if (trap_q != TRAP_NONE)  cnt_trap  <= sat_inc(cnt_trap);
                else if (is_load_op(op_q))  cnt_load  <= sat_inc(cnt_load);
                else if (is_store_op(op_q)) cnt_store <= sat_inc(cnt_store);
            end
        end
    end

    assign rsp_data    = data_q;
    assign rsp_trap    = trap_q;
    assign mem_rd_addr = addr_q;
    assign mem_rd_op   = op_q;
    assign mem_wr_addr = addr_q;
    assign mem_wr_op   = op_q;
    assign mem_wr_data = wdata_q;

endmodule

// File: tb/tb_wasm_lsu.sv
// Directed bench for wasm_lsu: scoreboard queue of expected responses checked
// by an independent monitor, plus latency, port and counter checks per request.
module tb_wasm_lsu;
    import wasm_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    mem_op_t     req_op = LOAD_I32;
    logic [31:0] req_base = '0;
    logic [31:0] req_offset = '0;
    logic [63:0] req_wdata = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [63:0] rsp_data;
    trap_t       rsp_trap;
    logic        mem_rd_en;
    logic [31:0] mem_rd_addr;
    mem_op_t     mem_rd_op;
    logic [63:0] mem_rd_data = '0;
    logic        mem_rd_valid = 1'b0;
    logic        mem_wr_en;
    logic [31:0] mem_wr_addr;
    mem_op_t     mem_wr_op;
    logic [63:0] mem_wr_data;
    logic        mem_wr_valid;
    trap_t       mem_trap = TRAP_NONE;
    logic [31:0] cnt_load, cnt_store, cnt_trap;
    lsu_state_t  fsm_state;

    logic        wr_ack_en = 1'b1;
    int          checks = 0;
    int          errors = 0;
    int          exp_ld = 0, exp_st = 0, exp_tr = 0;
    logic [65:0] exp_q[$];

    wasm_lsu dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_base(req_base), .req_offset(req_offset), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_trap(rsp_trap),
        .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_op(mem_rd_op),
        .mem_rd_data(mem_rd_data), .mem_rd_valid(mem_rd_valid),
        .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_op(mem_wr_op),
        .mem_wr_data(mem_wr_data), .mem_wr_valid(mem_wr_valid), .mem_trap(mem_trap),
        .cnt_load(cnt_load), .cnt_store(cnt_store), .cnt_trap(cnt_trap),
        .fsm_state(fsm_state)
    );

    always #5 clk = ~clk;

    // Memory write acknowledge arrives one cycle after an accepted write.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) mem_wr_valid <= 1'b0;
        else        mem_wr_valid <= mem_wr_en && wr_ack_en && (mem_trap == TRAP_NONE);
    end

    task automatic check(input string name, input logic [65:0] act, input logic [65:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp actual=%0h required=none", {rsp_trap, rsp_data});
            end else begin
                check("rsp_payload", {rsp_trap, rsp_data}, exp_q.pop_front());
            end
        end
    end

    task automatic check_counters(input string tag);
        check({tag, "_cnt_load"},  {34'd0, cnt_load},  66'(exp_ld));
        check({tag, "_cnt_store"}, {34'd0, cnt_store}, 66'(exp_st));
        check({tag, "_cnt_trap"},  {34'd0, cnt_trap},  66'(exp_tr));
    endtask

    // kind: 0 = other op, 1 = load, 2 = store; decides which counter should move.
    task automatic run_req(input string tag, input mem_op_t op, input logic [31:0] base,
                           input logic [31:0] off, input logic [63:0] wdata,
                           input logic [63:0] rdata, input logic rvalid, input trap_t mtrap,
                           input int exp_lat, input int exp_rd, input int exp_wr,
                           input logic [31:0] exp_addr, input logic [63:0] exp_data,
                           input trap_t exp_trap, input int kind, input int hold);
        int lat = 0;
        int rd_n = 0;
        int wr_n = 0;
        int both = 0;
        @(posedge clk); #1;
        req_valid = 1'b1; req_op = op; req_base = base; req_offset = off; req_wdata = wdata;
        mem_rd_data = rdata; mem_rd_valid = rvalid; mem_trap = mtrap;
        rsp_ready = (hold == 0);
        exp_q.push_back({exp_trap, exp_data});
        @(negedge clk);
        check({tag, "_req_ready"}, {65'd0, req_ready}, 66'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        while (1) begin
            @(negedge clk);
            lat++;
            if (mem_rd_en) begin
                rd_n++;
                check({tag, "_rd_addr"}, {34'd0, mem_rd_addr}, {34'd0, exp_addr});
            end
            if (mem_wr_en) begin
                wr_n++;
                check({tag, "_wr_addr"}, {34'd0, mem_wr_addr}, {34'd0, exp_addr});
                check({tag, "_wr_data"}, {2'd0, mem_wr_data}, {2'd0, wdata});
            end
            if (mem_rd_en && mem_wr_en) both++;
            if (rsp_valid || lat > 20) break;
        end
        check({tag, "_latency"}, 66'(lat), 66'(exp_lat));
        check({tag, "_rd_pulses"}, 66'(rd_n), 66'(exp_rd));
        check({tag, "_wr_pulses"}, 66'(wr_n), 66'(exp_wr));
        check({tag, "_rd_wr_overlap"}, 66'(both), 66'd0);
        if (hold > 0) begin
            for (int k = 0; k < hold; k++) begin
                check({tag, "_hold_valid"}, {65'd0, rsp_valid}, 66'd1);
                check({tag, "_hold_ready"}, {65'd0, req_ready}, 66'd0);
                check({tag, "_hold_payload"}, {rsp_trap, rsp_data}, {exp_trap, exp_data});
                @(negedge clk);
            end
            @(posedge clk); #1;
            rsp_ready = 1'b1;
            @(negedge clk);
        end
        @(posedge clk);
        @(negedge clk);
        check({tag, "_ready_after"}, {65'd0, req_ready}, 66'd1);
        if (exp_trap != TRAP_NONE) exp_tr++;
        else if (kind == 1)        exp_ld++;
        else if (kind == 2)        exp_st++;
        check_counters(tag);
        mem_trap = TRAP_NONE;
        mem_rd_valid = 1'b0;
    endtask

    initial begin
        int stray;
        #1;
        check("rst_req_ready", {65'd0, req_ready}, 66'd0);
        check("rst_rsp_valid", {65'd0, rsp_valid}, 66'd0);
        check("rst_mem_en", {64'd0, mem_rd_en, mem_wr_en}, 66'd0);
        check_counters("rst");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_payload", {rsp_trap, rsp_data}, 66'd0);

        run_req("load_i32", LOAD_I32, 32'h100, 32'h4, 64'h0, 64'h0000_0000_DEAD_BEEF, 1'b1,
                TRAP_NONE, 2, 1, 0, 32'h104, 64'h0000_0000_DEAD_BEEF, TRAP_NONE, 1, 0);
        run_req("ovf_load", LOAD_I64, 32'hFFFF_FFF0, 32'h20, 64'h0, 64'h55, 1'b1,
                TRAP_NONE, 1, 0, 0, 32'h0, 64'h0, TRAP_OUT_OF_BOUNDS, 1, 0);
        run_req("store_i64", STORE_I64, 32'h8, 32'h0, 64'h0123_4567_89AB_CDEF, 64'h0, 1'b0,
                TRAP_NONE, 3, 0, 1, 32'h8, 64'h0, TRAP_NONE, 2, 0);
        run_req("store_mtrap", STORE_I32, 32'h40, 32'h0, 64'hAAAA_BBBB_CCCC_DDDD, 64'h0, 1'b0,
                TRAP_OUT_OF_BOUNDS, 2, 0, 1, 32'h40, 64'h0, TRAP_OUT_OF_BOUNDS, 2, 0);
        run_req("load_mtrap", LOAD_I16_U, 32'h1000, 32'h2, 64'h0, 64'h1234, 1'b0,
                TRAP_OUT_OF_BOUNDS, 2, 1, 0, 32'h1002, 64'h0, TRAP_OUT_OF_BOUNDS, 1, 0);
        run_req("backpressure", LOAD_I64, 32'h200, 32'h10, 64'h0, 64'h1122_3344_5566_7788, 1'b1,
                TRAP_NONE, 2, 1, 0, 32'h210, 64'h1122_3344_5566_7788, TRAP_NONE, 1, 5);
        run_req("other_op", MEM_SIZE, 32'h0, 32'h0, 64'h0, 64'h0, 1'b0,
                TRAP_NONE, 1, 0, 0, 32'h0, 64'h0, TRAP_NONE, 0, 0);
        run_req("store_top", STORE_I8, 32'hFFFF_FFFF, 32'h0, 64'h0000_0000_0000_00A5, 64'h0, 1'b0,
                TRAP_NONE, 3, 0, 1, 32'hFFFF_FFFF, 64'h0, TRAP_NONE, 2, 0);
        run_req("store_ovf", STORE_I8, 32'hFFFF_FFFF, 32'h1, 64'h5A, 64'h0, 1'b0,
                TRAP_NONE, 1, 0, 0, 32'h0, 64'h0, TRAP_OUT_OF_BOUNDS, 2, 0);

        // Abort a store sitting in WR_WAIT with an asynchronous reset.
        wr_ack_en = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b1; req_op = STORE_I32_FROM_I64; req_base = 32'h80; req_offset = 32'h0;
        req_wdata = 64'hFEED;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("abort_in_wr_wait", 66'(fsm_state), 66'(WR_WAIT));
        #2 rst_n = 1'b0;
        #1;
        check("abort_state", 66'(fsm_state), 66'(IDLE));
        check("abort_req_ready", {65'd0, req_ready}, 66'd0);
        check("abort_rsp_valid", {65'd0, rsp_valid}, 66'd0);
        check("abort_mem_en", {64'd0, mem_rd_en, mem_wr_en}, 66'd0);
        exp_ld = 0; exp_st = 0; exp_tr = 0;
        check_counters("abort");
        wr_ack_en = 1'b1;
        @(posedge clk); #1 rst_n = 1'b1;
        stray = 0;
        repeat (6) begin
            @(negedge clk);
            if (rsp_valid) stray++;
        end
        check("abort_no_rsp", 66'(stray), 66'd0);

        run_req("post_reset", LOAD_I8_U, 32'h300, 32'h1, 64'h0, 64'h0000_0000_0000_007F, 1'b1,
                TRAP_NONE, 2, 1, 0, 32'h301, 64'h0000_0000_0000_007F, TRAP_NONE, 1, 0);

        repeat (2) @(negedge clk);
        check("scoreboard_drained", 66'(exp_q.size()), 66'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wasm_lsu.md
WASM_LSU -- requirements
Module: wasm_lsu

Interface
REQ-001 Parameter: none; all widths fixed (address 32, data 64); mem_op_t and trap_t come from wasm_pkg.
REQ-002 clk  input  1  clock; all state updates on posedge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req_valid  input  1  execute stage presents a memory instruction.
REQ-005 req_ready  output  1  LSU accepts the request this cycle.
REQ-006 req_op  input  mem_op_t  load/store kind.
REQ-007 req_base  input  32  address operand popped from the stack.
REQ-008 req_offset  input  32  memarg offset immediate.
REQ-009 req_wdata  input  64  store value, ignored for loads.
REQ-010 rsp_valid  output  1  result available.
REQ-011 rsp_ready  input  1  execute stage consumes the result.
REQ-012 rsp_data  output  64  load result, 0 for stores and traps.
REQ-013 rsp_trap  output  trap_t  TRAP_NONE or TRAP_OUT_OF_BOUNDS.
REQ-014 mem_rd_en, mem_rd_addr[32], mem_rd_op  outputs  read port to linear memory.
REQ-015 mem_rd_data[64], mem_rd_valid  inputs  combinational read return.
REQ-016 mem_wr_en, mem_wr_addr[32], mem_wr_op, mem_wr_data[64]  outputs  write port.
REQ-017 mem_wr_valid  input  1  write committed, registered one cycle after mem_wr_en.
REQ-018 mem_trap  input  trap_t  combinational trap for the current rd/wr request.
REQ-019 cnt_load, cnt_store, cnt_trap  outputs  32 each  saturating event counters.

Function
REQ-020 FSM states: IDLE, RD, WR, WR_WAIT, RESP.
REQ-021 req_ready = 1 only in IDLE; handshake on req_valid & req_ready latches op, wdata and the 33-bit effective address ea = {0,base} + {0,offset}.
REQ-022 On accept: if ea[32] = 1, go to RESP with TRAP_OUT_OF_BOUNDS and issue no memory access.
REQ-023 On accept: a load op goes to RD, a store op (STORE_I8/I16/I32/I32_FROM_I64/I64) goes to WR, any other op goes to RESP with data 0 and TRAP_NONE.
REQ-024 RD: drive mem_rd_en = 1, mem_rd_addr = ea[31:0], mem_rd_op = op for exactly one cycle.
REQ-025 RD: capture mem_rd_data if mem_rd_valid, otherwise capture data 0 with trap = mem_trap; then go to RESP.
REQ-026 WR: drive mem_wr_en for exactly one cycle, with mem_wr_data = wdata unmodified; the memory handles truncation.
REQ-027 WR: if mem_trap != TRAP_NONE, go to RESP with that trap; otherwise go to WR_WAIT.
REQ-028 WR_WAIT: stay until mem_wr_valid = 1, then go to RESP with TRAP_NONE.
REQ-029 RESP: rsp_valid = 1 with data and trap held stable until rsp_ready; on rsp_valid & rsp_ready go to IDLE.
REQ-030 Back-to-back requests are not overlapped.
REQ-031 Latency from accept to rsp_valid: load 2 cycles, store 3 cycles, overflow trap 1 cycle.
REQ-032 mem_rd_en and mem_wr_en are never asserted in the same cycle, and both are 0 outside RD/WR.
REQ-033 Counters increment at the RESP handshake:
- cnt_load on a load without trap;
- cnt_store on a store without trap;
- cnt_trap on any trap.
- All counters saturate at 32'hFFFFFFFF.

Reset
REQ-034 Reset returns the FSM to IDLE, asynchronously.
REQ-035 During reset: req_ready = 0 and rsp_valid = 0.
REQ-036 Reset clears all counters, mem_rd_en and mem_wr_en to 0.
REQ-037 Reset clears latched address, data and trap to 0/TRAP_NONE.
REQ-038 Reset mid-operation (RD, WR or WR_WAIT) aborts the operation with no response.

Structure
REQ-039 A lsu_state_t enum and an is_store_op/is_load_op helper function belong in wasm_pkg alongside mem_op_t and trap_t.
REQ-040 The block is a single module with no sub-module; the counters are inline logic.

Verification
REQ-041 Load path: base=0x100, offset=0x4, I32 load, memory returns 0xDEADBEEF.
- mem_rd_addr = 0x104 in the cycle after accept.
- rsp_data = 0x00000000DEADBEEF two cycles after accept; cnt_load = 1.
REQ-042 Address overflow: base=0xFFFFFFF0, offset=0x20, any op.
- No mem_rd_en/mem_wr_en.
- rsp_trap = TRAP_OUT_OF_BOUNDS one cycle after accept; cnt_trap = 1.
REQ-043 Store path: I64 store to 0x8, data 0x0123456789ABCDEF, mem_wr_valid the next cycle.
- One mem_wr_en pulse carrying that data.
- rsp_valid three cycles after accept.
REQ-044 Memory trap: store with mem_trap = TRAP_OUT_OF_BOUNDS in the WR cycle.
- Response carries that trap; WR_WAIT is skipped; cnt_store does not increment.
REQ-045 Backpressure: hold rsp_ready = 0 for 5 cycles.
- rsp_data and rsp_trap stay stable; req_ready = 0 throughout.
- After the handshake, req_ready = 1 in the next cycle.
REQ-046 Reset mid-operation: assert rst_n = 0 while in WR_WAIT.
- Outputs return to their reset values immediately; no rsp_valid after release.
